// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
           mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
           mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester data-memory arbiter: fetch (0, read-only) and load/store (1).
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 1.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic          clk,
  input  logic          rstn,
  mem_arbiter_if.slave  bus
);
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_owner;
  logic              r_m0_gnt;
  logic              r_m1_gnt;
  logic              r_m0_rvalid;
  logic              r_m1_rvalid;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_any;
  logic w_win;

  assign w_any = bus.m0_req | bus.m1_req;

`ifdef MEM_ARB_RR_EN
  logic r_last;
  // On contention the requester that did not own the previous command wins.
  assign w_win = (bus.m0_req & bus.m1_req) ? ~r_last : bus.m1_req;
`else
  assign w_win = bus.m1_req;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_m0_gnt    <= 1'b0;
      r_m1_gnt    <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
      r_last      <= 1'b1;
`endif
    end else begin
      r_m0_gnt    <= 1'b0;
      r_m1_gnt    <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          // The command registers double as the latched transaction.
          if (w_any) begin
            r_owner     <= w_win;
            r_m0_gnt    <= ~w_win;
            r_m1_gnt    <= w_win;
            r_mem_addr  <= w_win ? bus.m1_addr : bus.m0_addr;
            r_mem_wdata <= w_win ? bus.m1_wdata : '0;
            r_mem_we    <= w_win & bus.m1_we;
            r_mem_re    <= ~(w_win & bus.m1_we);
            r_state     <= S_CMD;
          end else begin
            r_state     <= S_IDLE;
          end
        end
        S_CMD: begin
`ifdef MEM_ARB_RR_EN
          r_last <= r_owner;
`endif
          if (r_mem_we) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= CNT_W'(LAT);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_cnt <= '0;
            if (r_owner) begin
              r_m1_rdata  <= bus.mem_rdata;
              r_m1_rvalid <= 1'b1;
            end else begin
              r_m0_rdata  <= bus.mem_rdata;
              r_m0_rvalid <= 1'b1;
            end
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m0_gnt    = r_m0_gnt;
  assign bus.m1_gnt    = r_m1_gnt;
  assign bus.m0_rvalid = r_m0_rvalid;
  assign bus.m1_rvalid = r_m1_rvalid;
  assign bus.m0_rdata  = r_m0_rdata;
  assign bus.m1_rdata  = r_m1_rdata;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LAT=1 and LAT=3) against a transaction-level model
// that schedules expected grants, commands and read responses by cycle number.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int NL    = 2;
  localparam int NCYC  = 2048;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT_A)) u_dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT_B)) u_dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

  typedef struct packed {
    logic gnt0, gnt1, re, we, rv0, rv1;
    logic [31:0] addr, wdata, rd0, rd1;
  } obs_t;

  typedef struct packed {
    logic req0;
    logic [31:0] addr0;
    logic req1, we1;
    logic [31:0] addr1, wdata1, rdata;
  } inp_t;

  typedef struct packed {
    logic gnt0, gnt1, re, we, rv0, rv1;
    logic [31:0] addr, wdata, rdv;
  } ev_t;

  typedef struct packed {
    logic act, we, pulse;
    logic [31:0] addr, wdata;
  } rq_t;

  obs_t        obs [NL];
  inp_t        inp [NL];
  ev_t         sched [NL][NCYC];
  rq_t         rq [NL][2];
  logic [31:0] model_mem [NL][256];
  logic [31:0] env_mem [NL][256];
  logic        re_hist [NL][NCYC];
  logic [31:0] ah_hist [NL][NCYC];
  int          next_sample [NL];
  logic        last [NL];
  logic [31:0] exp_rd0 [NL];
  logic [31:0] exp_rd1 [NL];
  int          lat [NL];
  int          cyc;
  int          pct;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input int lane, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s lane=%0d cyc=%0d observed=%h expected=%h", tag, lane, cyc, o, e);
    end
  endtask

  task automatic pull();
    obs[0].gnt0 = bus_a.m0_gnt;    obs[0].gnt1 = bus_a.m1_gnt;
    obs[0].re   = bus_a.mem_re;    obs[0].we   = bus_a.mem_we;
    obs[0].rv0  = bus_a.m0_rvalid; obs[0].rv1  = bus_a.m1_rvalid;
    obs[0].addr = bus_a.mem_addr;  obs[0].wdata = bus_a.mem_wdata;
    obs[0].rd0  = bus_a.m0_rdata;  obs[0].rd1  = bus_a.m1_rdata;
    obs[1].gnt0 = bus_b.m0_gnt;    obs[1].gnt1 = bus_b.m1_gnt;
    obs[1].re   = bus_b.mem_re;    obs[1].we   = bus_b.mem_we;
    obs[1].rv0  = bus_b.m0_rvalid; obs[1].rv1  = bus_b.m1_rvalid;
    obs[1].addr = bus_b.mem_addr;  obs[1].wdata = bus_b.mem_wdata;
    obs[1].rd0  = bus_b.m0_rdata;  obs[1].rd1  = bus_b.m1_rdata;
  endtask

  task automatic push();
    bus_a.m0_req = inp[0].req0;  bus_a.m0_addr = inp[0].addr0;
    bus_a.m1_req = inp[0].req1;  bus_a.m1_we   = inp[0].we1;
    bus_a.m1_addr = inp[0].addr1; bus_a.m1_wdata = inp[0].wdata1;
    bus_a.mem_rdata = inp[0].rdata;
    bus_b.m0_req = inp[1].req0;  bus_b.m0_addr = inp[1].addr0;
    bus_b.m1_req = inp[1].req1;  bus_b.m1_we   = inp[1].we1;
    bus_b.m1_addr = inp[1].addr1; bus_b.m1_wdata = inp[1].wdata1;
    bus_b.mem_rdata = inp[1].rdata;
  endtask

  task automatic issue(input int r, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic pulse);
    for (int l = 0; l < NL; l++) begin
      rq[l][r].act   = 1'b1;
      rq[l][r].we    = we;
      rq[l][r].pulse = pulse;
      rq[l][r].addr  = addr;
      rq[l][r].wdata = wdata;
    end
  endtask

  // One clock cycle: check outputs, react as memory, drive requesters, update the model.
  task automatic step();
    ev_t e;
    ev_t e2;
    int  w;
    logic r0, r1;
    if (cyc + 8 >= NCYC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "cycle budget exhausted");
    end
    pull();
    for (int l = 0; l < NL; l++) begin
      e = sched[l][cyc];
      chk("gnt0", l, 32'(obs[l].gnt0), 32'(e.gnt0));
      chk("gnt1", l, 32'(obs[l].gnt1), 32'(e.gnt1));
      chk("mem_re", l, 32'(obs[l].re), 32'(e.re));
      chk("mem_we", l, 32'(obs[l].we), 32'(e.we));
      chk("rvalid0", l, 32'(obs[l].rv0), 32'(e.rv0));
      chk("rvalid1", l, 32'(obs[l].rv1), 32'(e.rv1));
      if (e.re || e.we) chk("mem_addr", l, obs[l].addr, e.addr);
      if (e.we) chk("mem_wdata", l, obs[l].wdata, e.wdata);
      if (e.rv0) exp_rd0[l] = e.rdv;
      if (e.rv1) exp_rd1[l] = e.rdv;
      chk("rdata0", l, obs[l].rd0, exp_rd0[l]);
      chk("rdata1", l, obs[l].rd1, exp_rd1[l]);

      re_hist[l][cyc] = obs[l].re;
      ah_hist[l][cyc] = obs[l].addr;
      if (obs[l].we === 1'b1) env_mem[l][obs[l].addr[9:2]] = obs[l].wdata;
      if (cyc >= lat[l] && re_hist[l][cyc-lat[l]] === 1'b1)
        inp[l].rdata = env_mem[l][ah_hist[l][cyc-lat[l]][9:2]];
      else
        inp[l].rdata = $urandom;

      for (int r = 0; r < 2; r++) begin
        if (rq[l][r].act && ((r == 0) ? obs[l].gnt0 : obs[l].gnt1) === 1'b1) rq[l][r].act = 1'b0;
        if (!rq[l][r].act && rstn && $urandom_range(99) < pct) begin
          rq[l][r].act   = 1'b1;
          rq[l][r].pulse = 1'b0;
          rq[l][r].we    = (r == 1) && ($urandom_range(1) == 1);
          rq[l][r].addr  = $urandom;
          rq[l][r].wdata = $urandom;
        end
      end
      inp[l].req0   = rq[l][0].act;
      inp[l].addr0  = rq[l][0].act ? rq[l][0].addr : $urandom;
      inp[l].req1   = rq[l][1].act;
      inp[l].we1    = rq[l][1].act ? rq[l][1].we : ($urandom_range(1) == 1);
      inp[l].addr1  = rq[l][1].act ? rq[l][1].addr : $urandom;
      inp[l].wdata1 = rq[l][1].act ? rq[l][1].wdata : $urandom;

      if (cyc == next_sample[l]) begin
        r0 = inp[l].req0;
        r1 = inp[l].req1;
        if (!(r0 || r1)) begin
          next_sample[l] = cyc + 1;
        end else begin
`ifdef MEM_ARB_RR_EN
          w = (r0 && r1) ? (last[l] ? 0 : 1) : (r1 ? 1 : 0);
          last[l] = (w == 1);
`else
          w = r1 ? 1 : 0;
`endif
          e = '0;
          if (w == 1) begin
            e.gnt1 = 1'b1; e.addr = inp[l].addr1; e.wdata = inp[l].wdata1;
            e.we = inp[l].we1; e.re = !inp[l].we1;
          end else begin
            e.gnt0 = 1'b1; e.addr = inp[l].addr0; e.re = 1'b1;
          end
          sched[l][cyc+1] = e;
          if (e.we) begin
            model_mem[l][e.addr[9:2]] = e.wdata;
            next_sample[l] = cyc + 2;
          end else begin
            e2 = '0;
            if (w == 1) e2.rv1 = 1'b1; else e2.rv0 = 1'b1;
            e2.rdv = model_mem[l][e.addr[9:2]];
            sched[l][cyc+2+lat[l]] = e2;
            next_sample[l] = cyc + 2 + lat[l];
          end
        end
      end
      for (int r = 0; r < 2; r++)
        if (rq[l][r].act && rq[l][r].pulse) rq[l][r].act = 1'b0;
    end
    push();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset: outputs must clear at once, pending work is abandoned.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    pull();
    for (int l = 0; l < NL; l++) begin
      chk("rst_gnt0", l, 32'(obs[l].gnt0), 32'd0);
      chk("rst_gnt1", l, 32'(obs[l].gnt1), 32'd0);
      chk("rst_re", l, 32'(obs[l].re), 32'd0);
      chk("rst_we", l, 32'(obs[l].we), 32'd0);
      chk("rst_rv0", l, 32'(obs[l].rv0), 32'd0);
      chk("rst_rv1", l, 32'(obs[l].rv1), 32'd0);
      chk("rst_addr", l, obs[l].addr, 32'd0);
      chk("rst_wdata", l, obs[l].wdata, 32'd0);
      chk("rst_rd0", l, obs[l].rd0, 32'd0);
      chk("rst_rd1", l, obs[l].rd1, 32'd0);
      for (int c = cyc; c < NCYC; c++) sched[l][c] = '0;
      exp_rd0[l] = '0;
      exp_rd1[l] = '0;
      last[l] = 1'b1;
      rq[l][0].act = 1'b0;
      rq[l][1].act = 1'b0;
      next_sample[l] = NCYC + 100;
    end
    step();
    step();
    rstn = 1'b1;
    for (int l = 0; l < NL; l++) next_sample[l] = cyc;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    pct = 0;
    lat[0] = LAT_A;
    lat[1] = LAT_B;
    for (int l = 0; l < NL; l++) begin
      inp[l] = '0;
      rq[l][0] = '0;
      rq[l][1] = '0;
      for (int c = 0; c < NCYC; c++) begin
        re_hist[l][c] = 1'b0;
        ah_hist[l][c] = '0;
      end
    end
    for (int i = 0; i < 256; i++) begin
      model_mem[0][i] = $urandom;
      model_mem[1][i] = model_mem[0][i];
      env_mem[0][i]   = model_mem[0][i];
      env_mem[1][i]   = model_mem[0][i];
    end
    for (int l = 0; l < NL; l++) begin
      model_mem[l][4]  = 32'hDEADBEEF; env_mem[l][4]  = 32'hDEADBEEF;
      model_mem[l][16] = 32'hA5A5A5A5; env_mem[l][16] = 32'hA5A5A5A5;
    end
    push();
    #2;
    do_reset();

    // single read of 0x10 by requester 0
    issue(0, 1'b0, 32'h10, 32'h0, 1'b0);
    run(8);
    for (int l = 0; l < NL; l++) chk("tp_single_rdata", l, obs[l].rd0, 32'hDEADBEEF);

    // contention: requester 0 read vs requester 1 write
    issue(0, 1'b0, 32'h0, 32'h0, 1'b0);
    issue(1, 1'b1, 32'h20, 32'h12345678, 1'b0);
    run(10);

    // read of 0x40 by requester 1
    issue(1, 1'b0, 32'h40, 32'h0, 1'b0);
    run(10);
    for (int l = 0; l < NL; l++) chk("tp_latency_rdata", l, obs[l].rd1, 32'hA5A5A5A5);

    // request high for a single sampling cycle only
    issue(0, 1'b0, 32'h80, 32'h0, 1'b1);
    run(10);

    // random traffic, then continuous contention, then drain
    pct = 40;
    run(500);
    pct = 100;
    run(100);
    pct = 0;
    run(20);

    // reset while both instances are in WAIT
    issue(0, 1'b0, 32'h44, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h48, 32'h0, 1'b0);
    run(2);
    do_reset();
    issue(0, 1'b0, 32'h10, 32'h0, 1'b0);
    run(10);

    pct = 30;
    run(200);
    pct = 0;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
